// File: rtl/mem_stage_sram_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the SRAM-backed memory-access stage:
//   - state_e           : access sequencer states (IDLE, LO, HI, DONE)
//   - SRAM_AW / SRAM_DW : external SRAM address / data widths
//   - DEFAULT_BASE_ADDR : byte address mapped to SRAM word 0
//   - CNT_W             : width of the per-half wait counter
//   - word_index()      : byte address -> 17-bit SRAM word index
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int unsigned SRAM_AW           = 18;
    localparam int unsigned SRAM_DW           = 16;
    localparam int unsigned CNT_W             = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Offset wraps modulo 2^32; bits [18:2] select the 32-bit word, so
    // the byte offset is dropped and anything above bit 18 aliases.
    function automatic logic [SRAM_AW-2:0] word_index(input logic [31:0] alu,
                                                      input logic [31:0] base);
        return (SRAM_AW-1)'((alu - base) >> 2);
    endfunction

endpackage

// File: rtl/mem_stage_sram_if.sv
// -----------------------------------------------------------------------------
// mem_stage_sram_if
// Pipeline-side bus between the EXE stage register and the memory stage.
//   Mem_R_en, Mem_W_en : load / store request      (master -> slave)
//   ALU_result         : byte address              (master -> slave)
//   Val_Rm             : store data                (master -> slave)
//   ready              : no access pending / MEM register load enable
//                                                  (slave -> master)
//   Mem_read_value     : last loaded word          (slave -> master)
// -----------------------------------------------------------------------------
interface mem_stage_sram_if;

    logic        Mem_R_en;
    logic        Mem_W_en;
    logic [31:0] ALU_result;
    logic [31:0] Val_Rm;
    logic        ready;
    logic [31:0] Mem_read_value;

    modport master (
        output Mem_R_en, Mem_W_en, ALU_result, Val_Rm,
        input  ready, Mem_read_value
    );

    modport slave (
        input  Mem_R_en, Mem_W_en, ALU_result, Val_Rm,
        output ready, Mem_read_value
    );

endinterface

// File: rtl/mem_stage_sram_phase_counter.sv
// -----------------------------------------------------------------------------
// sram_phase_counter
// Wait counter for one 16-bit half access. Counts 0..WAIT_CYCLES-1 while
// enabled and wraps to 0 after the terminal count.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : force count to 0
//   en_i     : advance the count
//   last     : count is at WAIT_CYCLES-1 (terminal count)
// -----------------------------------------------------------------------------
module sram_phase_counter
    import mem_stage_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_stage_sram.sv
// -----------------------------------------------------------------------------
// mem_stage_sram
// Memory-access stage: splits a 32-bit load/store into two 16-bit accesses
// on an asynchronous SRAM (low half first) and stalls the pipeline through
// `ready` while the access is in flight.
//
// Parameters:
//   BASE_ADDR   : byte address mapped to SRAM word 0
//   WAIT_CYCLES : cycles per 16-bit half access (1..15)
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : pipeline side (slave modport of mem_stage_sram_if)
//   SRAM_ADDR   : SRAM half-word address
//   SRAM_DQ     : SRAM data bus (driven only during writes)
//   SRAM_WE_N   : SRAM write enable, active low
//   addr_err    : misaligned / out-of-range request flag, DONE cycle only
//                 (port exists only when MEM_ADDR_CHECK_EN is defined)
// Build option:
//   MEM_ADDR_CHECK_EN : reject misaligned or out-of-window addresses
//                       without touching the SRAM.
// -----------------------------------------------------------------------------
module mem_stage_sram
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    mem_stage_sram_if.slave     bus,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
    output logic                SRAM_WE_N
`ifdef MEM_ADDR_CHECK_EN
    ,
    output logic                addr_err
`endif
);

    state_e               state_q;
    logic                 wr_q;
    logic [SRAM_AW-2:0]   widx_q;
    logic [SRAM_DW-1:0]   wdata_hi_q;
    logic [31:0]          rdata_q;
    logic [SRAM_AW-1:0]   addr_q;
    logic                 we_n_q;
    logic                 dq_oe_q;
    logic [SRAM_DW-1:0]   dq_q;
    logic                 err_q;

    logic                 req;
    logic                 in_phase;
    logic                 phase_last;
    logic                 bad_addr;
    logic [SRAM_AW-2:0]   req_widx;

    assign req      = bus.Mem_R_en | bus.Mem_W_en;
    assign in_phase = (state_q == ST_LO) || (state_q == ST_HI);
    assign req_widx = word_index(bus.ALU_result, BASE_ADDR);

`ifdef MEM_ADDR_CHECK_EN
    logic [31:0] offset;
    assign offset   = bus.ALU_result - BASE_ADDR;
    assign bad_addr = (bus.ALU_result[1:0] != 2'b00)
                   || (bus.ALU_result < BASE_ADDR)
                   || ((offset >> (SRAM_AW + 1)) != '0);
    assign addr_err = err_q;
`else
    logic unused_err;
    assign bad_addr   = 1'b0;
    assign unused_err = err_q;
`endif

    sram_phase_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_phase_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!in_phase),
        .en_i  (in_phase),
        .last  (phase_last)
    );

    // DONE releases the stall regardless of inputs; IDLE stalls as soon as
    // a request appears so the freeze takes effect in the request cycle.
    assign bus.ready          = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
    assign bus.Mem_read_value = rdata_q;
    assign SRAM_ADDR          = addr_q;
    assign SRAM_WE_N          = we_n_q;
    assign SRAM_DQ            = dq_oe_q ? dq_q : 'z;

    // SRAM pin values are registered one state ahead so they line up with
    // the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            widx_q     <= '0;
            wdata_hi_q <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            we_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
            dq_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        // Write wins when both enables are set.
                        wr_q       <= bus.Mem_W_en;
                        widx_q     <= req_widx;
                        wdata_hi_q <= bus.Val_Rm[31:16];
                        if (bad_addr) begin
                            state_q <= ST_DONE;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_LO;
                            addr_q  <= {req_widx, 1'b0};
                            we_n_q  <= !bus.Mem_W_en;
                            dq_oe_q <= bus.Mem_W_en;
                            dq_q    <= bus.Val_Rm[15:0];
                        end
                    end
                end
                ST_LO: begin
                    if (phase_last) begin
                        if (!wr_q) begin
                            rdata_q[15:0] <= SRAM_DQ;
                        end
                        state_q <= ST_HI;
                        addr_q  <= {widx_q, 1'b1};
                        dq_q    <= wdata_hi_q;
                    end
                end
                ST_HI: begin
                    if (phase_last) begin
                        if (!wr_q) begin
                            rdata_q[31:16] <= SRAM_DQ;
                        end
                        state_q <= ST_DONE;
                        addr_q  <= '0;
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
